// File: rtl/legv8_pkg.sv
// Shared LEGv8 pipeline definitions for the hazard controller and its helpers.
package legv8_pkg;

  // Hardwired zero register; reading it never waits on a producer.
  localparam logic [4:0] XZR_REG = 5'd31;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [4:0] rd;
  } shadow_t;

  // Per-cycle pipeline action.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } cycle_t;

  localparam shadow_t SHADOW_EMPTY = '{valid: 1'b0, reg_write: 1'b0, rd: 5'd0};

  // True when the entry is a live writer of register r.
  function automatic logic src_hit(input shadow_t e, input logic [4:0] r);
    return e.valid && e.reg_write && (e.rd == r);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count one per asserted inc, holding once every bit is set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// RAW hazard and branch flush control for the 5-stage LEGv8 pipeline.
// A shadow copy of the EX and MEM destination fields is kept locally so the
// decision depends only on what the ID instruction reads.
module hazard_ctrl
  import legv8_pkg::*;
#(
  parameter int         CNT_W = 16,
  parameter logic [4:0] XZR   = XZR_REG
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic [4:0]       id_rt,
  input  logic             id_reg2loc,
  input  logic             id_uses_rn,
  input  logic             id_uses_r2,
  input  logic             id_reg_write,
  input  logic [4:0]       id_rd,
  input  logic             mem_branch_taken,
  output logic             r2_sel,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             ex_mem_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  shadow_t    ex_q;
  shadow_t    mem_q;
  logic [4:0] src2;
  logic       rn_haz;
  logic       r2_haz;
  logic       raw_hazard;
  cycle_t     cyc_class;
  logic       stall_evt;
  logic       flush_evt;

  assign src2   = id_reg2loc ? id_rt : id_rm;
  assign r2_sel = id_reg2loc;

  // A source waits if it is read, is not the zero register, and a live
  // producer still sits in EX or MEM; WB writes first so it never blocks.
  always_comb begin
    rn_haz     = id_uses_rn && (id_rn != XZR) &&
                 (src_hit(ex_q, id_rn) || src_hit(mem_q, id_rn));
    r2_haz     = id_uses_r2 && (src2 != XZR) &&
                 (src_hit(ex_q, src2) || src_hit(mem_q, src2));
    raw_hazard = id_valid && (rn_haz || r2_haz);
  end

  // Taken branch beats any hazard; reset forces a clean RUN so a stall
  // releases the moment reset rises.
  always_comb begin
    cyc_class = RUN;
    if (reset) begin
      cyc_class = RUN;
    end else if (mem_branch_taken) begin
      cyc_class = FLUSH;
    end else if (raw_hazard) begin
      cyc_class = STALL;
    end
  end

  // Pipeline register controls for the chosen action.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    case (cyc_class)
      STALL: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
      FLUSH: begin
        id_ex_bubble = 1'b1;
        if_id_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end
      default: begin
        pc_write = 1'b1;
      end
    endcase
  end

  // Shadow pipeline: ID enters EX only when it really advances, and a taken
  // branch kills the instruction moving from EX into MEM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= SHADOW_EMPTY;
      mem_q <= SHADOW_EMPTY;
    end else begin
      if (cyc_class == RUN) begin
        ex_q <= '{valid: id_valid, reg_write: id_reg_write, rd: id_rd};
      end else begin
        ex_q <= SHADOW_EMPTY;
      end
      if (mem_branch_taken) begin
        mem_q <= SHADOW_EMPTY;
      end else begin
        mem_q <= ex_q;
      end
    end
  end

  assign stall_evt = (cyc_class == STALL);
  assign flush_evt = (cyc_class == FLUSH);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_evt),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_evt),
    .count (flush_cnt)
  );

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the saturating stall and flush event counters.
REQ-002 SHALL have parameter XZR, default 5'd31, register number that never causes a hazard.
REQ-003 SHALL have port clk  input  1  single rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port id_valid  input  1  the IF/ID register holds a real instruction.
REQ-006 SHALL have port id_rn  input  5  first source register field of the ID instruction.
REQ-007 SHALL have port id_rm  input  5  Rm field of the ID instruction.
REQ-008 SHALL have port id_rt  input  5  Rt field of the ID instruction.
REQ-009 SHALL have port id_reg2loc  input  1  decoded Reg2Loc: 0 selects Rm as second source, 1 selects Rt.
REQ-010 SHALL have port id_uses_rn / id_uses_r2  input  1 each  the ID instruction reads source 1 / source 2.
REQ-011 SHALL have port id_reg_write, id_rd  input  1, 5  the ID instruction writes register id_rd.
REQ-012 SHALL have port mem_branch_taken  input  1  a branch resolved taken in MEM this cycle.
REQ-013 SHALL have port r2_sel  output  1  select for the 5-bit second-read-register mux; equals id_reg2loc.
REQ-014 SHALL have ports pc_write, if_id_write  output  1 each  hold PC and IF/ID when 0.
REQ-015 SHALL have ports id_ex_bubble, if_id_flush, ex_mem_flush  output  1 each  zero the control bits of the named pipeline register.
REQ-016 SHALL have ports stall_cnt, flush_cnt  output  CNT_W each  event counters.

Function
REQ-017 SHALL keep a 2-entry shadow pipeline (EX, MEM), each entry {valid, reg_write, rd}, advancing every clock.
REQ-018 SHALL load EX from {id_valid, id_reg_write, id_rd} when not stalling, and with valid=0 when stalling or flushing.
REQ-019 SHALL load MEM from EX each cycle, and with valid=0 when mem_branch_taken is asserted.
REQ-020 SHALL compute src2 = id_reg2loc ? id_rt : id_rm.
REQ-021 SHALL flag a RAW hazard when id_valid and a used source (id_rn or src2) equals the rd of a valid, reg_write shadow entry (EX or MEM), and that source is not XZR.
REQ-022 SHALL classify each cycle as RUN, STALL or FLUSH: FLUSH if mem_branch_taken, else STALL if a RAW hazard, else RUN.
REQ-023 In RUN: pc_write=1, if_id_write=1, and all bubble/flush outputs 0.
REQ-024 In STALL: pc_write=0, if_id_write=0, id_ex_bubble=1, and both flush outputs 0.
REQ-025 In FLUSH: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1; FLUSH overrides a simultaneous hazard.
REQ-026 SHALL make all control outputs combinational from the current inputs and shadow state, with zero-cycle latency.
REQ-027 SHALL make an EX-stage producer stall a dependent instruction exactly 2 cycles, and a MEM-stage producer exactly 1 cycle (write-first register file in WB).
REQ-028 SHALL increment stall_cnt on every STALL cycle and flush_cnt on every FLUSH cycle, each saturating at all-ones.
REQ-029 SHALL hold r2_sel = id_reg2loc at all times, including stall and flush cycles.

Reset
REQ-030 On reset, SHALL clear both shadow entries (valid=0, reg_write=0, rd=0) and zero both counters, immediately and asynchronously.
REQ-031 While reset is asserted, SHALL drive the RUN output values; asserting reset mid-stall SHALL release the stall within the same cycle.

Structure
REQ-032 SHALL place the XZR constant, the shadow-entry struct and the RUN/STALL/FLUSH encoding in a shared package, legv8_pkg.
REQ-033 SHALL use one sub-module, sat_counter (parameter CNT_W, ports clk, reset, inc, count), instantiated twice.

Verification
REQ-034 ADD X1 followed by SUB X2,X1,X3 -> 2 STALL cycles (pc_write=0, id_ex_bubble=1), then RUN; stall_cnt=2.
REQ-035 ADD X1, then an unrelated instruction, then SUB X2,X1,X3 -> exactly 1 STALL cycle.
REQ-036 ADD X31 followed by SUB X2,X31,X3 -> no stall; STUR X1 with reg2loc=1 after ADD X1 -> stall on Rt match.
REQ-037 mem_branch_taken in the same cycle as a RAW hazard -> FLUSH outputs all 1, pc_write=1, flush_cnt=1, shadow cleared, no stall next cycle.
REQ-038 Force stall_cnt to all-ones with CNT_W=4 (16 stall cycles) -> counter holds 4'hF.
REQ-039 Assert reset during the second STALL cycle -> pc_write=1 immediately; counters and shadow read 0 after release.
